// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - host-to-device PS/2 command transmitter
// Drives the open-collector clock/data lines through low-only output enables.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES = 150000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SEND,
    S_WAIT_IDLE
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      byte_q, byte_d;
  logic [IW-1:0]   inh_q, inh_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic [3:0]      bit_q, bit_d;
  logic            clk_oe_q, clk_oe_d;
  logic            data_oe_q, data_oe_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic            clk_s1_q, clk_s2_q, clk_s3_q;
  logic            dat_s1_q, dat_s2_q;
  logic            fall;

  // Synchronisers idle high so reset never fabricates a falling edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      clk_s3_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk_in;
      clk_s2_q <= clk_s1_q;
      clk_s3_q <= clk_s2_q;
      dat_s1_q <= ps2_data_in;
      dat_s2_q <= dat_s1_q;
    end
  end

  assign fall = clk_s3_q & ~clk_s2_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      byte_q    <= 8'h00;
      inh_q     <= '0;
      wd_q      <= '0;
      bit_q     <= 4'd0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      inh_q     <= inh_d;
      wd_q      <= wd_d;
      bit_q     <= bit_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    inh_d     = inh_q;
    wd_d      = wd_q;
    bit_d     = bit_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        inh_d     = '0;
        wd_d      = '0;
        bit_d     = 4'd0;
        if (tx_valid) begin
          byte_d   = tx_data;
          clk_oe_d = 1'b1;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inh_q == INH_LAST) begin
          data_oe_d = 1'b1;
          state_d   = S_RTS;
        end else begin
          inh_d = inh_q + 1'b1;
        end
      end
      S_RTS: begin
        clk_oe_d = 1'b0;
        wd_d     = '0;
        bit_d    = 4'd0;
        state_d  = S_SEND;
      end
      S_SEND: begin
        // A device edge always beats a simultaneous watchdog expiry.
        if (fall) begin
          wd_d  = '0;
          bit_d = bit_q + 4'd1;
          if (bit_q < 4'd8) begin
            data_oe_d = ~byte_q[bit_q[2:0]];
          end else if (bit_q == 4'd8) begin
            data_oe_d = ^byte_q;
          end else if (bit_q == 4'd9) begin
            data_oe_d = 1'b0;
          end else if (!dat_s2_q) begin
            state_d = S_WAIT_IDLE;
          end else begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end
        end else if (wd_q == WD_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          error_d   = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (clk_s2_q && dat_s2_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (fall) begin
          wd_d = '0;
        end else if (wd_q == WD_LAST) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  assign tx_ready    = (state_q == S_IDLE);
  assign tx_busy     = ~tx_ready;
  assign tx_done     = done_q;
  assign tx_error    = error_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed bench for ps2_host_tx with a PS/2 device model
// The device drives its own clock/data and wire-ANDs them with the host enables.
module tb_ps2_host_tx;

  localparam int INH = 1000;
  localparam int TMO = 50;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, tx_done, tx_error;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       clk_line, data_line;

  int n_chk = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  assign clk_line  = ~ps2_clk_oe & dev_clk;
  assign data_line = ~ps2_data_oe & dev_data;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .ps2_clk_in (clk_line),
    .ps2_data_in(data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (tx_done === 1'b1) done_cnt++;
    if (tx_error === 1'b1) err_cnt++;
    if (tx_done === 1'b1 && tx_error === 1'b1) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Called one step after the accepting edge.
  task automatic inhibit_checks();
    chk("inh_first_clk_oe", 32'(ps2_clk_oe), 32'd1);
    chk("inh_first_data_oe", 32'(ps2_data_oe), 32'd0);
    chk("inh_first_busy", 32'(tx_busy), 32'd1);
    cyc(INH - 1);
    chk("inh_last_clk_oe", 32'(ps2_clk_oe), 32'd1);
    chk("inh_last_data_oe", 32'(ps2_data_oe), 32'd0);
    cyc(1);
    chk("rts_clk_oe", 32'(ps2_clk_oe), 32'd1);
    chk("rts_data_oe", 32'(ps2_data_oe), 32'd1);
    cyc(1);
    chk("send_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("send_data_oe", 32'(ps2_data_oe), 32'd1);
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    while (tx_ready === 1'b1 && n < 100) begin
      cyc(1);
      n++;
    end
    chk("accept", 32'(tx_ready), 32'd0);
    inhibit_checks();
  endtask

  // Device: 10 cycles high, 10 cycles low per bit, sampling at the end of low.
  task automatic dev_run(input logic [7:0] b, input logic ack, input int nfalls);
    logic expb;
    for (int i = 1; i <= nfalls; i++) begin
      if (i == 11) begin
        cyc(5);
        dev_data = ~ack;
        cyc(5);
      end else begin
        cyc(10);
      end
      dev_clk = 1'b0;
      cyc(10);
      if (i <= 10) begin
        if (i <= 8) expb = b[i-1];
        else if (i == 9) expb = ~^b;
        else expb = 1'b1;
        chk($sformatf("bit%0d_of_%02h", i, b), 32'(data_line), 32'(expb));
      end
      if (i < nfalls || nfalls == 11) dev_clk = 1'b1;
    end
    if (nfalls == 11) begin
      cyc(2);
      dev_data = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic ack);
    tx_data  = b;
    tx_valid = 1'b1;
    wait_accept();
    tx_valid = 1'b0;
    dev_run(b, ack, 11);
    cyc(30);
  endtask

  task automatic idle_checks(input string tag, input int d_exp, input int e_exp);
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'(d_exp));
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(e_exp));
    chk({tag, "_ready"}, 32'(tx_ready), 32'd1);
    chk({tag, "_clk_oe"}, 32'(ps2_clk_oe), 32'd0);
    chk({tag, "_data_oe"}, 32'(ps2_data_oe), 32'd0);
  endtask

  initial begin
    int d0, e0, n;

    cyc(3);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    chk("rst_error", 32'(tx_error), 32'd0);
    resetn = 1'b1;
    cyc(2);

    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'hED, 1'b1);
    idle_checks("ed", d0 + 1, e0);

    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h00, 1'b1);
    idle_checks("zero", d0 + 1, e0);

    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h55, 1'b0);
    idle_checks("nack", d0, e0 + 1);

    // Silent device: error lands exactly TMO cycles after clock release.
    d0 = done_cnt; e0 = err_cnt;
    tx_data  = 8'hF4;
    tx_valid = 1'b1;
    wait_accept();
    tx_valid = 1'b0;
    cyc(TMO - 1);
    chk("tmo_early", 32'(tx_error), 32'd0);
    cyc(1);
    chk("tmo_pulse", 32'(tx_error), 32'd1);
    chk("tmo_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("tmo_data_oe", 32'(ps2_data_oe), 32'd0);
    chk("tmo_ready", 32'(tx_ready), 32'd1);
    tx_valid = 1'b0;
    cyc(5);
    idle_checks("tmo", d0, e0 + 1);

    // Busy: valid held with a new byte throughout the first frame.
    d0 = done_cnt; e0 = err_cnt;
    tx_data  = 8'hA6;
    tx_valid = 1'b1;
    wait_accept();
    tx_data = 8'h3C;
    dev_run(8'hA6, 1'b1, 11);
    n = 0;
    while (tx_ready !== 1'b1 && n < 60) begin
      cyc(1);
      n++;
    end
    chk("busy_ready_back", 32'(tx_ready), 32'd1);
    chk("busy_done_same_cycle", 32'(tx_done), 32'd1);
    chk("busy_one_done", 32'(done_cnt), 32'(d0));
    cyc(1);
    chk("busy_reaccept", 32'(tx_ready), 32'd0);
    tx_valid = 1'b0;
    inhibit_checks();
    dev_run(8'h3C, 1'b1, 11);
    cyc(30);
    idle_checks("busy", d0 + 2, e0);
    cyc(30);
    chk("busy_sent_once", 32'(ps2_clk_oe), 32'd0);

    // Reset after the fifth device fall, mid clock cycle.
    d0 = done_cnt; e0 = err_cnt;
    tx_data  = 8'h0F;
    tx_valid = 1'b1;
    wait_accept();
    tx_valid = 1'b0;
    dev_run(8'h0F, 1'b1, 5);
    chk("mid_data_oe", 32'(ps2_data_oe), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("rstmid_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("rstmid_data_oe", 32'(ps2_data_oe), 32'd0);
    chk("rstmid_ready", 32'(tx_ready), 32'd1);
    dev_clk = 1'b1;
    cyc(3);
    resetn = 1'b1;
    cyc(5);
    idle_checks("rstmid", d0, e0);

    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'hFF, 1'b1);
    idle_checks("ff", d0 + 1, e0);

    chk("never_both", 32'(both_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
